// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int PC_W_DEFAULT = 10;

  typedef logic [PC_W_DEFAULT-1:0] pc_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select: hold, sequential +1, absolute or PC-relative branch.
// All arithmetic wraps modulo 2^PC_W.
module pc_next
  import fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0] pc,
  input  logic            hold,
  input  logic            branch_en,
  input  logic            branch_abs,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc_nxt
);

  always_comb begin
    pc_nxt = pc + PC_W'(1);
    if (hold) begin
      pc_nxt = pc;
    end else if (branch_en) begin
      // relative offset is two's complement; truncated add gives the modulo wrap
      pc_nxt = branch_abs ? target : (pc + target);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC and start/halt run protocol; all outputs registered.
// INST_FETCH_COUNT_EN builds the saturating instr_count, otherwise it is tied to 0.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             branch_abs,
  input  logic [PC_W-1:0]  target,
  input  logic             halt_req,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             halt,
  output logic [CNT_W-1:0] instr_count
);

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc_nxt;
  logic            pc_hold;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // abort via start outranks halt_req while running
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ARMED;
      ARMED:   if (!start) state_n = RUN;
      RUN: begin
        if (start)         state_n = ARMED;
        else if (halt_req) state_n = HALTED;
      end
      HALTED:  if (start) state_n = ARMED;
      default: state_n = IDLE;
    endcase
  end

  assign pc_hold = halt_req | stall;

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc         (pc),
    .hold       (pc_hold),
    .branch_en  (branch_en),
    .branch_abs (branch_abs),
    .target     (target),
    .pc_nxt     (pc_nxt)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      fetch_valid <= 1'b0;
      halt        <= 1'b0;
    end else begin
      fetch_valid <= (state_n == RUN);
      halt        <= (state_n == HALTED);
      if (state_n == ARMED)  pc <= '0;
      else if (state == RUN) pc <= pc_nxt;
    end
  end

`ifdef INST_FETCH_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_n == ARMED) begin
      cnt <= '0;
    end else if (state == RUN && !stall && !start && cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign instr_count = cnt;
`else
  assign instr_count = '0;
`endif

endmodule
